fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a synchronous FIFO read port (one-cycle read latency)
// into a valid/ready stream through a 2-entry skid buffer (head, tail).
// m_data comes straight from the head register. fifo_rd_en is the only
// combinational output; it depends on m_ready through the pop term.
//
// Handshake: a word moves downstream on every edge where m_valid and m_ready
// are both 1. m_valid never drops and m_data never changes while m_valid=1 and
// m_ready=0. Upstream, a word is popped on each edge with fifo_rd_en=1 and is
// present on fifo_rd_data during the following cycle, when r_inflight=1.
//
// Optional feature: define FIFO_RD_STREAM_STATS_EN to add the xfer_cnt output.
// It is a 32-bit count of accepted stream words that wraps at the top, is
// cleared by reset and is cleared by flush.
module fifo_rd_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]      xfer_cnt
`endif
);

  // The occupancy of the output buffer is the state of this block.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       r_occ;
  logic [1:0]       w_occ_nxt;
  logic             r_inflight;
  logic             r_rst_done;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_pop;
  logic [2:0]       w_level;
  logic             w_post_pop_empty;

  assign m_valid = (r_occ != S_EMPTY);
  assign m_data  = r_head;
  assign w_pop   = m_valid & m_ready;

  // w_level is the word count after this edge: buffered plus arriving minus
  // leaving. A pop implies occ >= 1, so this cannot go negative. Reads are
  // issued only while it is below 2, so occ + inflight never exceeds 2.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  // The head slot is the target for an arriving word when it is free after this edge's pop.
  assign w_post_pop_empty = (r_occ == S_EMPTY) | ((r_occ == S_ONE) & w_pop);

  // Pop request: gated until the first edge after reset release, and by flush.
  assign fifo_rd_en = r_rst_done & ~fifo_empty & ~flush & (w_level < 3'd2);

  // Next-occupancy selection; flush discards everything, including a pop.
  always_comb begin
    w_occ_nxt = r_occ;
    if (flush) begin
      w_occ_nxt = S_EMPTY;
    end else begin
      case (w_level)
        3'd0:    w_occ_nxt = S_EMPTY;
        3'd1:    w_occ_nxt = S_ONE;
        default: w_occ_nxt = S_TWO;
      endcase
    end
  end

  // Occupancy, in-flight flag and the reset-release qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= S_EMPTY;
      r_inflight <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= fifo_rd_en;
      r_rst_done <= 1'b1;
    end
  end

  // Buffer data path: shift tail into head on a pop from TWO, and place an
  // arriving word in head if head is free after the pop, otherwise in tail.
  // While flush is high, the buffer holds its contents and no word is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!flush) begin
      if (w_pop && (r_occ == S_TWO)) begin
        r_head <= r_tail;
      end
      if (r_inflight) begin
        if (w_post_pop_empty) begin
          r_head <= fifo_rd_data;
        end else begin
          r_tail <= fifo_rd_data;
        end
      end
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] r_xfer_cnt;

  // Count accepted stream words; wraps naturally and is cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= 32'd0;
    end else if (flush) begin
      r_xfer_cnt <= 32'd0;
    end else if (w_pop) begin
      r_xfer_cnt <= r_xfer_cnt + 32'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
